// File: rtl/lzd_arbiter.sv
// Round-robin arbiter that shares one multi-cycle leading-zero detector
// among NUM_REQ requesters. It captures the granted operand, launches the
// detector, supervises it with a watchdog and returns the tagged result.
//
// Response handshake: rsp_valid rises when a result is ready and stays high,
// with rsp_id/rsp_count/rsp_all_zero/rsp_err frozen, until the cycle in which
// rsp_ready is also high; the transfer happens on that rising edge and
// rsp_valid drops the cycle after.
module lzd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 7,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CNT_W-1:0]          rsp_count,
  output logic                      rsp_all_zero,
  output logic                      rsp_err,
  output logic                      lzd_start,
  output logic [DATA_W-1:0]         lzd_data,
  input  logic [CNT_W-1:0]          lzd_count,
  input  logic                      lzd_all_zero,
  input  logic                      lzd_busy,
  input  logic                      lzd_done
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state;
  logic              armed;      // set after the first LAUNCH cycle (the ack cycle)
  logic [ID_W-1:0]   last_gnt;
  logic [WD_W-1:0]   wd;

  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_idx;
  logic              hi_found;
  logic [ID_W-1:0]   hi_idx;
  logic [ID_W-1:0]   lo_idx;
  logic [DATA_W-1:0] sel_data;

  // Start is offered one cycle after the ack and only while the detector is free.
  assign lzd_start = (state == LAUNCH) && armed && !lzd_busy;

  // Round-robin pick: lowest requester above last_gnt, else lowest overall (wrap).
  always_comb begin
    gnt_valid = 1'b0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_valid = 1'b1;
        lo_idx    = ID_W'(i);
        if (i > int'(last_gnt)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    gnt_idx = hi_found ? hi_idx : lo_idx;
  end

  // Operand slice of the requester being granted.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Sequencer: grant, launch, wait with watchdog, hold response until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      armed        <= 1'b0;
      last_gnt     <= ID_W'(NUM_REQ - 1);
      wd           <= '0;
      req_ack      <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_count    <= '0;
      rsp_all_zero <= 1'b0;
      rsp_err      <= 1'b0;
      lzd_data     <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            lzd_data <= sel_data;
            rsp_id   <= gnt_idx;
            last_gnt <= gnt_idx;
            req_ack  <= NUM_REQ'(1) << gnt_idx;
            armed    <= 1'b0;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          armed <= 1'b1;
          if (lzd_start) begin
            armed <= 1'b0;
            wd    <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          wd <= wd + 1'b1;
          // A completion in the expiry cycle still delivers a good result.
          if (lzd_done) begin
            rsp_count    <= lzd_count;
            rsp_all_zero <= lzd_all_zero;
            rsp_err      <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            rsp_count    <= '0;
            rsp_all_zero <= 1'b0;
            rsp_err      <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lzd_arbiter.sv
// Testbench for lzd_arbiter: behavioural detector, requester driver,
// round-robin reference model and response scoreboard.
module tb_lzd_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 7;
  localparam int TIMEOUT = 255;
  localparam int RW      = ID_W + CNT_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b1;
  logic [ID_W-1:0]           rsp_id;
  logic [CNT_W-1:0]          rsp_count;
  logic                      rsp_all_zero;
  logic                      rsp_err;
  logic                      lzd_start;
  logic [DATA_W-1:0]         lzd_data;
  logic [CNT_W-1:0]          lzd_count;
  logic                      lzd_all_zero;
  logic                      lzd_busy;
  logic                      lzd_done;

  lzd_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_count(rsp_count), .rsp_all_zero(rsp_all_zero), .rsp_err(rsp_err),
    .lzd_start(lzd_start), .lzd_data(lzd_data), .lzd_count(lzd_count),
    .lzd_all_zero(lzd_all_zero), .lzd_busy(lzd_busy), .lzd_done(lzd_done)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Leading-zero count straight from its definition.
  function automatic int lzc(input logic [63:0] x);
    for (int i = 63; i >= 0; i--) if (x[i]) return 63 - i;
    return 64;
  endfunction

  // Next grant: first requesting index after last, wrapping.
  function automatic int model_next(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = (last + k) % NUM_REQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // ---------------- behavioural detector ----------------
  int   det_lat = 3;
  bit   det_hang = 1'b0;
  logic spur_done = 1'b0;
  logic det_busy = 1'b0;
  logic det_done = 1'b0;
  logic [CNT_W-1:0] det_count = '0;
  logic det_zero = 1'b0;
  int   det_rem = 0;

  assign lzd_busy     = det_busy;
  assign lzd_done     = det_done | spur_done;
  assign lzd_count    = det_count;
  assign lzd_all_zero = det_zero;

  // Done arrives det_lat cycles after the start cycle; in hang mode starts are ignored.
  always @(posedge clk) begin
    det_done <= 1'b0;
    if (lzd_start && !det_busy && !det_hang) begin
      det_count <= CNT_W'(lzc(lzd_data));
      det_zero  <= (lzd_data == '0);
      if (det_lat <= 1) det_done <= 1'b1;
      else begin
        det_busy <= 1'b1;
        det_rem  <= det_lat - 1;
      end
    end else if (det_busy) begin
      if (det_rem == 1) begin
        det_busy <= 1'b0;
        det_done <= 1'b1;
      end
      det_rem <= det_rem - 1;
    end
  end

  // ---------------- requesters, monitor, scoreboard ----------------
  logic [63:0]   dq[NUM_REQ][$];
  logic [RW-1:0] exp_q[$];
  int            gnt_log[$];
  bit            rdy_rand = 1'b0;
  logic          rdy_val = 1'b1;
  int            model_last = NUM_REQ - 1;
  logic          prev_valid = 1'b0;
  int            last_req_cyc = 0, last_ack_cyc = 0, last_start_cyc = 0, last_valid_cyc = 0;
  int            n_start = 0;
  logic [NUM_REQ-1:0] last_ack_val = '0;
  logic [RW-1:0] last_rsp = '0;
  int            g_id, e_id;
  logic [63:0]   g_data;

  always @(negedge clk) begin
    rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    if (!rst_n) model_last = NUM_REQ - 1;
    if (lzd_start) begin
      last_start_cyc = cyc;
      n_start++;
    end
    if (rsp_valid && !prev_valid) last_valid_cyc = cyc;
    prev_valid = rsp_valid;

    if (req_ack != '0) begin
      last_ack_cyc = cyc;
      last_ack_val = req_ack;
      chk("ack_onehot", $countones(req_ack), 1);
      g_id = 0;
      for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) g_id = i;
      e_id = model_next(req, model_last);
      chk("grant_order", g_id, e_id);
      model_last = e_id;
      gnt_log.push_back(g_id);
      chk("ack_has_req", dq[g_id].size() > 0, 1);
      if (dq[g_id].size() > 0) begin
        g_data = dq[g_id].pop_front();
        if (det_hang) exp_q.push_back({ID_W'(g_id), CNT_W'(0), 1'b0, 1'b1});
        else exp_q.push_back({ID_W'(g_id), CNT_W'(lzc(g_data)), g_data == 0, 1'b0});
      end
    end

    if (rsp_valid && rsp_ready) begin
      last_rsp = {rsp_id, rsp_count, rsp_all_zero, rsp_err};
      chk("rsp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("rsp_fields", last_rsp, exp_q.pop_front());
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (dq[i].size() > 0) begin
        if (!req[i]) last_req_cyc = cyc;
        req[i] = 1'b1;
        req_data[i*DATA_W +: DATA_W] = dq[i][0];
      end else begin
        req[i] = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int id, input logic [63:0] d);
    dq[id].push_back(d);
  endtask

  function automatic bit all_idle();
    bit b;
    b = (exp_q.size() == 0) && (req == '0) && !rsp_valid;
    for (int i = 0; i < NUM_REQ; i++) if (dq[i].size() != 0) b = 1'b0;
    return b;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, all_idle(), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          id;
    logic [63:0] data;
    int          cnt;
    bit          zero;
  } vec_t;
  vec_t vt[7];
  int   rr_exp[8];

  initial begin : global_guard
    #900000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin : test
    int seen;
    int n0;
    int sh;
    logic [63:0] d;

    vt[0] = '{0, 64'h0,                   64, 1'b1};
    vt[1] = '{2, 64'h1,                   63, 1'b0};
    vt[2] = '{2, 64'h0000_0000_8000_0000, 32, 1'b0};
    vt[3] = '{1, 64'h8000_0000_0000_0000,  0, 1'b0};
    vt[4] = '{3, 64'hFFFF_FFFF_FFFF_FFFF,  0, 1'b0};
    vt[5] = '{1, 64'h0000_0001_0000_0000, 31, 1'b0};
    vt[6] = '{3, 64'h2,                   62, 1'b0};
    rr_exp = '{0, 1, 2, 3, 0, 1, 3, 1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ack", req_ack, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_lzd_start", lzd_start, 0);
    chk("reset_lzd_data", lzd_data, 0);
    chk("reset_rsp_fields", {rsp_id, rsp_count, rsp_all_zero, rsp_err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // minimum latency with a zero operand on requester 0, detector latency 3
    det_lat = 3;
    issue(0, 64'h0);
    wait_idle("lat_done", 200);
    chk("lat_req_to_ack", last_ack_cyc - last_req_cyc, 1);
    chk("lat_ack_value", last_ack_val, 4'b0001);
    chk("lat_ack_to_start", last_start_cyc - last_ack_cyc, 1);
    chk("lat_start_to_valid", last_valid_cyc - last_start_cyc, 4);
    chk("lat_rsp", last_rsp, {2'd0, 7'd64, 1'b1, 1'b0});

    // table-driven operands
    for (int i = 0; i < 7; i++) begin
      det_lat = 1 + (i % 4);
      issue(vt[i].id, vt[i].data);
      wait_idle("vec_done", 200);
      chk("vec_rsp", last_rsp, {ID_W'(vt[i].id), CNT_W'(vt[i].cnt), vt[i].zero, 1'b0});
    end

    // spurious done while idle must not produce a response
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("spurious_done_idle", seen, 0);

    // round robin from reset: all four held, then only 1 and 3 remain
    do_reset();
    gnt_log.delete();
    det_lat = 2;
    issue(0, {$urandom(), $urandom()}); issue(0, {$urandom(), $urandom()});
    issue(1, {$urandom(), $urandom()}); issue(1, {$urandom(), $urandom()});
    issue(1, {$urandom(), $urandom()});
    issue(2, {$urandom(), $urandom()});
    issue(3, {$urandom(), $urandom()}); issue(3, {$urandom(), $urandom()});
    wait_idle("rr_done", 400);
    chk("rr_count", gnt_log.size(), 8);
    for (int k = 0; k < 8; k++) if (k < gnt_log.size()) chk("rr_order", gnt_log[k], rr_exp[k]);

    // back-pressure: response held 5 cycles with requester 1 waiting
    gnt_log.delete();
    rdy_val = 1'b0;
    issue(2, 64'hFF);
    n0 = 0;
    while (!rsp_valid && n0 < 50) begin
      @(posedge clk); #1;
      n0++;
    end
    chk("bp_valid_seen", rsp_valid, 1);
    issue(1, 64'h10);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_fields", {rsp_id, rsp_count, rsp_all_zero, rsp_err}, {2'd2, 7'd56, 1'b0, 1'b0});
      chk("bp_no_ack", req_ack, 0);
    end
    @(posedge clk); #1;
    rdy_val = 1'b1;
    wait_idle("bp_done", 200);
    chk("bp_grants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) chk("bp_next_grant", gnt_log[1], 1);
    chk("bp_rsp1", last_rsp, {2'd1, 7'd59, 1'b0, 1'b0});

    // watchdog abort with a silent detector, then a normal operation
    det_hang = 1'b1;
    issue(3, 64'h1234);
    wait_idle("to_done", TIMEOUT + 50);
    chk("to_rsp", last_rsp, {2'd3, 7'd0, 1'b0, 1'b1});
    chk("to_latency", last_valid_cyc - last_start_cyc, TIMEOUT + 1);
    det_hang = 1'b0;
    det_lat = 2;
    issue(0, 64'h4);
    wait_idle("to_after", 200);
    chk("to_after_rsp", last_rsp, {2'd0, 7'd61, 1'b0, 1'b0});

    // reset while waiting on the detector
    det_lat = 10;
    n0 = n_start;
    issue(1, 64'h1);
    for (int k = 0; k < 30 && n_start == n0; k++) begin
      @(posedge clk); #1;
    end
    chk("rw_started", n_start != n0, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_req_ack", req_ack, 0);
    chk("rw_lzd_start", lzd_start, 0);
    chk("rw_lzd_data", lzd_data, 0);
    chk("rw_rsp_fields", {rsp_id, rsp_count, rsp_all_zero, rsp_err}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("rw_late_done_ignored", seen, 0);
    gnt_log.delete();
    det_lat = 2;
    issue(2, 64'h100);
    issue(0, 64'h3);
    wait_idle("rw_after", 200);
    chk("rw_first_grant", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

    // randomized traffic with random back-pressure and detector latency
    rdy_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      d  = {$urandom(), $urandom()};
      sh = $urandom_range(0, 64);
      d  = (sh == 64) ? 64'h0 : (d >> sh);
      issue($urandom_range(0, NUM_REQ - 1), d);
      det_lat = $urandom_range(1, 5);
      repeat ($urandom_range(0, 8)) @(posedge clk);
      #1;
    end
    wait_idle("rand_done", 3000);
    rdy_rand = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzd_arbiter.md
Name: lzd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle leading-zero detector (start/busy/done handshake, 64-bit data, 7-bit count) among NUM_REQ requesters.
- Captures a requester's operand, launches the detector, waits for completion and returns the count tagged with the requester ID through a valid/ready response port.
- Includes a watchdog that aborts a hung detector operation.
- Sits between the normalisation/priority-encode clients and the single shared lzd instance.

Parameters:
- NUM_REQ, 4, number of requesters.
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- DATA_W, 64, operand width.
- CNT_W, 7, count width; holds 0..DATA_W.
- TIMEOUT, 255, maximum WAIT cycles before abort; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held with data until the matching ack.
- req_data  in  NUM_REQ*DATA_W  operands; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-hot, 1-cycle pulse; operand captured this cycle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  ID of the requester being answered.
- rsp_count  out  CNT_W  leading-zero count.
- rsp_all_zero  out  1  operand was zero.
- rsp_err  out  1  watchdog abort; count and all_zero are 0.
- lzd_start  out  1  detector start.
- lzd_data  out  DATA_W  detector operand.
- lzd_count  in  CNT_W  detector count; valid while lzd_done=1.
- lzd_all_zero  in  1  detector zero flag; valid while lzd_done=1.
- lzd_busy  in  1  detector computing.
- lzd_done  in  1  detector 1-cycle completion pulse.

Behaviour:
- Reset is asynchronous on rst_n=0.
  - All outputs go to 0.
  - State goes to IDLE and the watchdog counter clears.
  - The round-robin pointer last_gnt is set to NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation drops the in-flight request without a response. The detector result that follows is ignored, because lzd_done is ignored outside WAIT.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req bit is set, grant the first requesting index after last_gnt, scanning upward and wrapping.
  - On that edge: latch req_data slice into lzd_data, latch ID, update last_gnt, pulse req_ack[ID] for exactly 1 cycle, go to LAUNCH.
  - With no requests, stay in IDLE.
  - At most one grant is made per operation.
- LAUNCH:
  - lzd_start = ~lzd_busy. lzd_data is held stable from capture until leaving WAIT.
  - Start is accepted on the edge where lzd_start=1. Then clear the watchdog and go to WAIT.
  - While lzd_busy=1, remain in LAUNCH with lzd_start=0.
- WAIT:
  - lzd_start=0. The watchdog increments each cycle.
  - On lzd_done=1: capture lzd_count into rsp_count and lzd_all_zero into rsp_all_zero; set rsp_err=0; go to RESP.
  - Otherwise, when the watchdog reaches TIMEOUT: set rsp_err=1, rsp_count=0, rsp_all_zero=0; go to RESP.
  - If lzd_done and timeout expiry occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1. rsp_id, rsp_count, rsp_all_zero and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready, go to IDLE. rsp_valid drops on the next cycle.
  - No new grant is made while in RESP; requests wait.
- Minimum latency, with an idle detector and lzd_done arriving D cycles after start:
  - req to req_ack: 1 cycle.
  - req_ack to lzd_start: 1 cycle.
  - lzd_start to rsp_valid: D+1 cycles.
- Spurious lzd_done in IDLE, LAUNCH or RESP is ignored.
- A req deasserted before grant is simply not granted.
- Expected detector values: count 64 for zero input; count 63 for input 1.

Test Plan:
- Reset, then req[0]=1 with data 0 → req_ack=4'b0001 one cycle later. Response: rsp_id=0, rsp_count=64, rsp_all_zero=1, rsp_err=0.
- req[2]=1 with data 64'h1 → rsp_id=2, rsp_count=63, rsp_all_zero=0. Data 64'h0000_0000_8000_0000 → rsp_count=32.
- req=4'b1111 held, rsp_ready=1 → grant order 0,1,2,3,0. Then drop all except req[1] and req[3] after granting 3 → order 1,3,1.
- Hold rsp_ready=0 for 5 cycles during RESP, with req[1] pending → rsp_valid and all rsp fields stable, no req_ack. Release rsp_ready → next grant goes to 1.
- lzd_done tied 0 → exactly TIMEOUT cycles after entering WAIT, rsp_valid with rsp_err=1, rsp_count=0. Next request then completes normally.
- rst_n pulsed low during WAIT → outputs 0 immediately. The late lzd_done is ignored (no rsp_valid). The first grant after reset goes to requester 0.
